// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: access sizes,
// FSM states and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    RESP
  } lsu_state_t;

  function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word by access size.
import lsu_pkg::*;

module load_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] result
);

  always_comb begin
    case (size)
      SIZE_B:  result = {{(XLEN-8){~uns & word[7]}}, word[7:0]};
      SIZE_H:  result = {{(XLEN-16){~uns & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage driving an 8-bit registered-read data memory with
// 1/2/4 sequential byte accesses per request and a one-cycle response.
import lsu_pkg::*;

module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_error,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out
);

  lsu_state_t        state_q, state_d;
  logic              wr_q, uns_q;
  logic [1:0]        size_q, cnt_q, last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0][7:0]   wdata_q, asm_q, asm_d;
  logic [XLEN-1:0]   ext;
  logic [2:0]        nbytes;
  logic              req_err, accept;

  always_comb begin
    nbytes  = bytes_for_size(req_size);
    last_d  = 2'(nbytes - 3'd1);
    req_err = (req_size == 2'b11) ||
              (req_size == SIZE_H && req_addr[0]) ||
              (req_size == SIZE_W && req_addr[1:0] != 2'b00);
    accept  = req_valid && (state_q == IDLE);
  end

  // Read data lags the strobe by a cycle, so byte i lands while byte i+1 is
  // being addressed; the final byte is picked up in DRAIN.
  always_comb begin
    asm_d = asm_q;
    if (state_q == ACCESS && !wr_q && cnt_q != 2'd0)
      asm_d[cnt_q - 2'd1] = mem_data_out;
    if (state_q == DRAIN)
      asm_d[last_q] = mem_data_out;
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .word   (asm_d),
    .size   (size_q),
    .uns    (uns_q),
    .result (ext)
  );

  always_comb begin
    state_d     = state_q;
    req_ready   = (state_q == IDLE);
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_address = addr_q + ADDR_W'(cnt_q);
        if (wr_q) begin
          mem_write   = 1'b1;
          mem_data_in = wdata_q[cnt_q];
        end else begin
          mem_read = 1'b1;
        end
        if (cnt_q == last_q) state_d = wr_q ? RESP : DRAIN;
      end
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      asm_q      <= '0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= '0;
      last_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        last_q  <= last_d;
        addr_q  <= req_addr;
        wdata_q <= req_wdata[31:0];
        cnt_q   <= '0;
        asm_q   <= '0;
      end else begin
        asm_q <= asm_d;
        if (state_q == ACCESS) cnt_q <= cnt_q + 2'd1;
      end
      resp_valid <= (state_d == RESP);
      resp_error <= accept && req_err;
      resp_rdata <= (state_q == DRAIN) ? ext : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: registered-read byte memory, request-level reference
// model of memory contents, directed cases followed by random requests.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_write, mem_read;
  logic [7:0]  mem_address, mem_data_in, mem_data_out;

  logic [7:0]  ram [0:255];
  logic [7:0]  ref_mem [0:255];
  logic        fill_en;
  logic [7:0]  fill_a, fill_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_W(8), .XLEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always @(posedge clock) begin
    if (fill_en) ram[fill_a] <= fill_d;
    else if (mem_write) ram[mem_address] <= mem_data_in;
    if (mem_read) mem_data_out <= ram[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_req();
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 8'($urandom);
    req_wdata    = $urandom;
  endtask

  // One request end to end: per-cycle strobe/address/data checks, then the
  // response cycle; the expected outcome is derived from the reference memory.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit us,
                        input logic [7:0] ad, input logic [31:0] wd,
                        output logic [31:0] got);
    int n, resp_c;
    bit err, exp_w, exp_r;
    logic [31:0] exp;
    n      = 1 << sz;
    err    = (sz == 2'd3) || ((int'(ad) % n) != 0);
    resp_c = err ? 1 : (wr ? n + 1 : n + 2);
    exp    = '0;
    if (!err && !wr) begin
      for (int i = 0; i < n; i++)
        exp = exp | (32'(ref_mem[8'(int'(ad) + i)]) << (8 * i));
      if (sz == 2'd0 && !us && exp[7])  exp = exp | 32'hFFFF_FF00;
      if (sz == 2'd1 && !us && exp[15]) exp = exp | 32'hFFFF_0000;
    end
    got = '0;

    @(negedge clock);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    check("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("idle_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = us; req_addr = ad; req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    scramble_req();

    for (int c = 1; c <= resp_c; c++) begin
      @(negedge clock);
      exp_w = !err && wr && (c <= n);
      exp_r = !err && !wr && (c <= n);
      check("mem_write", {31'd0, mem_write}, {31'd0, exp_w});
      check("mem_read", {31'd0, mem_read}, {31'd0, exp_r});
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (exp_w || exp_r)
        check("mem_address", {24'd0, mem_address}, {24'd0, 8'(int'(ad) + c - 1)});
      else
        check("mem_address_idle", {24'd0, mem_address}, 32'd0);
      if (exp_w)
        check("mem_data_in", {24'd0, mem_data_in}, {24'd0, 8'(wd >> (8 * (c - 1)))});
      else if (!exp_r)
        check("mem_data_in_idle", {24'd0, mem_data_in}, 32'd0);
      check("resp_valid", {31'd0, resp_valid}, {31'd0, c == resp_c});
      if (c == resp_c) begin
        check("resp_error", {31'd0, resp_error}, {31'd0, err});
        check("resp_rdata", resp_rdata, exp);
        got = resp_rdata;
      end else begin
        check("resp_rdata_hold", resp_rdata, 32'd0);
      end
    end

    if (wr && !err)
      for (int i = 0; i < n; i++)
        ref_mem[8'(int'(ad) + i)] = 8'(wd >> (8 * i));
  endtask

  initial begin
    logic [31:0] got, wd;
    bit          rw;
    logic [1:0]  sz;
    logic [7:0]  ad;

    reset = 1'b1;
    req_valid = 1'b0;
    scramble_req();
    fill_en = 1'b0; fill_a = '0; fill_d = '0;

    for (int a = 0; a < 256; a++) begin
      @(negedge clock);
      fill_en = 1'b1;
      fill_a  = 8'(a);
      fill_d  = 8'($urandom);
      ref_mem[a] = fill_d;
      req_valid = 1'($urandom);
    end
    @(negedge clock);
    fill_en = 1'b0;
    req_valid = 1'b0;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;

    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, got);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, got);
    check("lw_deadbeef", got, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, got);
    check("lb_signed", got, 32'hFFFF_FFDE);
    do_req(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, got);
    check("lbu", got, 32'h0000_00DE);
    do_req(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, got);
    check("lh_signed", got, 32'hFFFF_DEAD);
    do_req(1'b0, 2'd1, 1'b0, 8'h21, 32'h0, got);
    do_req(1'b1, 2'd2, 1'b0, 8'h22, 32'h1111_1111, got);
    do_req(1'b1, 2'd3, 1'b0, 8'h20, 32'h2222_2222, got);
    do_req(1'b1, 2'd1, 1'b0, 8'hFE, 32'h0000_1234, got);
    do_req(1'b0, 2'd1, 1'b1, 8'hFE, 32'h0, got);
    check("lhu_top", got, 32'h0000_1234);

    // Reset during the second byte of a word store: only byte 0 is committed.
    wd = $urandom;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 8'h40; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_addr = 8'h40;
    #1;
    check("mid_rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("mid_rst_addr", {24'd0, mem_address}, 32'd0);
    check("mid_rst_data", {24'd0, mem_data_in}, 32'd0);
    check("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    ref_mem[8'h40] = wd[7:0];
    repeat (3) @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
      check("post_rst_no_strobe", {30'd0, mem_write, mem_read}, 32'd0);
    end
    do_req(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, got);
    check("partial_low_byte", {24'd0, got[7:0]}, {24'd0, wd[7:0]});

    for (int t = 0; t < 80; t++) begin
      rw = 1'($urandom);
      sz = 2'($urandom);
      ad = 8'($urandom);
      if ($urandom_range(0, 1) == 0) ad = 8'h80 | (ad & 8'h0F);
      if (sz != 2'd3 && $urandom_range(0, 3) != 0)
        ad = ad & ~8'((1 << sz) - 1);
      do_req(rw, sz, 1'($urandom), ad, $urandom, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage sitting directly upstream of the 8-bit byte-wide data memory.
- Accepts one load/store request at a time from execute (valid/ready) and issues 1, 2 or 4 sequential byte accesses on the memory's write/read/address/data port.
- Assembles load bytes little-endian, then sign- or zero-extends them.
- Returns a single-cycle response to writeback.

Parameters:
- ADDR_W, 8, byte address width; must match the memory address width.
- XLEN, 32, register/response data width; fixed at 32 for the byte-count logic.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a clock edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data; low bytes used
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or illegal-size request; valid with resp_valid
- mem_write  out  1  to memory MemWrite
- mem_read  out  1  to memory MemRead
- mem_address  out  ADDR_W  to memory address
- mem_data_in  out  8  to memory data_in
- mem_data_out  in  8  from memory data_out; registered, valid the cycle after mem_read

Behaviour:
- States: IDLE, ACCESS, DRAIN, RESP.
- req_ready = 1 only in IDLE.
- Reset (async): state=IDLE, byte counter=0, assembly register=0, resp_valid=0, resp_rdata=0, resp_error=0.
- mem_write, mem_read, mem_address, mem_data_in are combinational decodes of state/counter/latched request, and are 0 outside ACCESS.
- Requests presented while reset is high are ignored.
- Accept at edge k (IDLE): latch write/size/unsigned/addr/wdata.
- Error check at accept: size=11; half with addr[0]=1; word with addr[1:0]!=00.
  - On error: go to RESP with error=1.
  - No memory strobe is ever driven for an errored request.
- Otherwise n = 1/2/4 by size, counter=0, go to ACCESS.
- ACCESS, cycles k+1 .. k+n; in cycle for byte i:
  - mem_address = addr + i (mod 2^ADDR_W). Wrap is unreachable for aligned requests but the arithmetic is defined mod 256.
  - Store: mem_write=1, mem_data_in = wdata[8i+7:8i].
  - Load: mem_read=1. At the end of this cycle, if i >= 1, capture mem_data_out into assembly byte i-1.
  - Exactly one strobe per cycle; mem_read and mem_write are never both high.
- After byte n-1: a store goes to RESP; a load goes to DRAIN.
- DRAIN (one cycle, loads only): capture mem_data_out into assembly byte n-1, then go to RESP.
- Latency from accept edge: store resp_valid in cycle k+n+1; load in cycle k+n+2; error in cycle k+1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Back-to-back requests are therefore separated by at least one RESP cycle.
- Load extension: byte/half take bit 7/15 as sign unless req_unsigned; word passes through; req_unsigned is ignored for word.
- resp_rdata and resp_error are registered and held 0 whenever resp_valid=0.
- req_valid dropping after acceptance has no effect.
- Reset mid-operation: return to IDLE immediately, with no rollback. Bytes already written by a partially completed store stay written, and no response is produced.

Decomposition:
- lsu_pkg holds:
  - size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state encoding (IDLE, ACCESS, DRAIN, RESP);
  - a function bytes_for_size(size) returning 1/2/4.
- One combinational sub-module, load_extend: inputs assembled word, size, unsigned; output extended XLEN result. It is shared with any future cache-side load path.

Test Plan:
- Store word 0xDEADBEEF at 0x10 -> mem_write high cycles k+1..k+4 at addresses 0x10..0x13 with data EF,BE,AD,DE; resp_valid in k+5 with rdata=0, error=0.
- Load word from 0x10 after the above -> mem_read cycles k+1..k+4; resp_valid in k+6 with rdata=0xDEADBEEF.
- Load byte at 0x13 (0xDE), signed then unsigned -> rdata 0xFFFFFFDE, then 0x000000DE. Load half at 0x12 signed -> 0xFFFFDEAD.
- Misaligned half at 0x21, word at 0x22, and size=11 -> resp_valid in k+1 with error=1, rdata=0; no mem strobe observed.
- Boundary: store half 0x1234 at 0xFE, then load it -> addresses 0xFE,0xFF; rdata=0x00001234 (unsigned).
- Reset asserted in cycle k+2 of a word store to 0x40 -> all outputs 0 immediately and no resp_valid. After release, req_ready=1. Loading 0x40 returns the new low byte and the old bytes at 0x42/0x43.
